// File: rtl/ldm_stm_seq.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_seq
// Brief    : LDM/STM block-transfer sequencer. Walks a 16-bit register list
//            lowest register first, issuing one register/memory transfer per
//            cycle at ascending word addresses, with optional base writeback.
// Config   : define LDMSTM_WB_EN to enable base writeback (WBK state).
// Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic        pre,
  input  logic        wb,
  input  logic [3:0]  rn,
  input  logic [31:0] base,
  input  logic [15:0] reglist,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rf_a,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic [31:0] wb_data,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        pc_we
);

`ifdef LDMSTM_WB_EN
  localparam bit WB_BUILD = 1'b1;
`else
  localparam bit WB_BUILD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WBK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] remaining;   // registers still to transfer after the current one
  logic [31:0] next_addr;   // address of the next transfer
  logic        load_q;
  logic        wbk_q;       // writeback cycle pending after the last transfer
  logic [3:0]  rn_q;

  logic [4:0]  pop_n;
  logic [31:0] four_n;
  logic [31:0] final_base;
  logic [31:0] first_addr;
  logic        take_first;
  logic        more;
  logic [15:0] xfer_list;
  logic [3:0]  xfer_idx;
  logic [31:0] xfer_addr;
  logic        xfer_load;
  logic        wbk_req;

  function automatic logic [4:0] count_ones(input logic [15:0] v);
    count_ones = 5'd0;
    for (int k = 0; k < 16; k++) count_ones = count_ones + {4'd0, v[k]};
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    lowest_bit = 4'd0;
    for (int k = 15; k >= 0; k--) if (v[k]) lowest_bit = 4'(k);
  endfunction

  // Address arithmetic and selection of the transfer issued at the next edge
  always_comb begin
    pop_n      = count_ones(reglist);
    four_n     = {25'd0, pop_n, 2'b00};
    final_base = up ? base + four_n : base - four_n;
    if (up) first_addr = pre ? base + 32'd4 : base;
    else    first_addr = pre ? base - four_n : base - four_n + 32'd4;
    take_first = (state == S_IDLE) && start && (pop_n != 5'd0);
    more       = take_first || ((state == S_XFER) && (remaining != 16'd0));
    xfer_list  = take_first ? reglist : remaining;
    xfer_idx   = lowest_bit(xfer_list);
    xfer_addr  = take_first ? first_addr : next_addr;
    xfer_load  = take_first ? is_load : load_q;
    // A load that also targets the base keeps the loaded value
    wbk_req    = WB_BUILD && wb && !(is_load && reglist[rn]);
  end

  assign busy = (state != S_IDLE);

  // Sequencer state and registered outputs for the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= 16'd0;
      next_addr <= 32'd0;
      load_q    <= 1'b0;
      wbk_q     <= 1'b0;
      rn_q      <= 4'd0;
      wb_data   <= 32'd0;
      done      <= 1'b0;
      rf_a      <= 4'd0;
      rf_we     <= 1'b0;
      rf_wsel   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_we    <= 1'b0;
      pc_we     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rf_a     <= 4'd0;
      rf_we    <= 1'b0;
      rf_wsel  <= 1'b0;
      mem_addr <= 32'd0;
      mem_we   <= 1'b0;
      pc_we    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            load_q  <= is_load;
            rn_q    <= rn;
            wbk_q   <= wbk_req;
            wb_data <= WB_BUILD ? final_base : 32'd0;
            if (pop_n == 5'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_XFER: begin
          if (remaining == 16'd0) begin
            if (wbk_q) begin
              state   <= S_WBK;
              rf_we   <= 1'b1;
              rf_wsel <= 1'b1;
              rf_a    <= rn_q;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_WBK: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // A transfer cycle follows: R15 loads redirect to the PC
      if (more) begin
        state     <= S_XFER;
        rf_a      <= xfer_idx;
        mem_addr  <= xfer_addr;
        mem_we    <= ~xfer_load;
        rf_we     <= xfer_load && (xfer_idx != 4'd15);
        pc_we     <= xfer_load && (xfer_idx == 4'd15);
        remaining <= xfer_list & ~(16'd1 << xfer_idx);
        next_addr <= xfer_addr + 32'd4;
      end
    end
  end

endmodule
`default_nettype wire
